lbus_master: RTL and testbench
==============================

Name: lbus_master

Overview:
Local-bus initiator that drives the SASEBO-GIII 16-bit multiplexed local bus from the control side. It generates the address, write and read cycles the crypto FPGA's bus interface consumes, so benches and the control FPGA can load keys and text and read ciphertext. It accepts one command at a time on a valid/ready interface and returns read data on a response strobe.

Parameters:
WR_CYC, 2, cycles lbus_wrn held low per write data phase (min 1)
RD_CYC, 3, cycles lbus_rdn held low per read (min 1); read data sampled on the last low cycle
GAP_CYC, 1, idle cycles after each access, with wrn=rdn=1 (min 0)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_wr  input  1  1 = write, 0 = read
cmd_addr  input  16  bus address
cmd_wdata  input  16  write data (ignored for reads)
rsp_valid  output  1  one-cycle pulse, read data valid
rsp_rdata  output  16  read data, held until the next read completes
busy  output  1  high from command acceptance through end of GAP
lbus_di_a  output  16  multiplexed address/data to target
lbus_wrn  output  1  write strobe, active-low
lbus_rdn  output  1  read strobe, active-low
lbus_do  input  16  read data from target

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=0, busy=0, rsp_valid=0, rsp_rdata=0, lbus_di_a=0, lbus_wrn=1, lbus_rdn=1, state=IDLE.
- rst wins over everything, including mid-transaction. Strobes return to 1 on the cycle after rst is sampled. Any partial command is dropped with no rsp_valid.
- States: IDLE, ADDR, WRITE, READ, GAP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_wr/cmd_addr/cmd_wdata, set busy=1, cmd_ready=0, and go to ADDR.
- ADDR, exactly 1 cycle:
  - lbus_di_a=addr, wrn=1, rdn=1. The target latches its address while wrn is high.
  - Then go to WRITE if wr, else READ.
- WRITE:
  - lbus_di_a=wdata, wrn=0 for WR_CYC cycles, then GAP.
- READ:
  - lbus_di_a=addr, rdn=0 for RD_CYC cycles.
  - On the last READ cycle, sample lbus_do into rsp_rdata.
  - rsp_valid pulses 1 on the first GAP cycle, or the first IDLE cycle if GAP_CYC=0.
- GAP:
  - lbus_di_a=addr, wrn=rdn=1 for GAP_CYC cycles, then IDLE. With GAP_CYC=0, go straight to IDLE.
  - busy clears on entry to IDLE.
- Invariants:
  - wrn and rdn are never both 0.
  - When wrn rises, lbus_di_a switches back to addr in that same cycle. This keeps data from being latched as a spurious address.
- Minimum back-to-back write spacing is 1+WR_CYC+GAP_CYC+1 cycles from accept to the next accept. IDLE always lasts at least one cycle.
- A single phase counter is sized to the max of the parameters. It resets to 0 on every state entry, and there is no wrap-around.
- cmd_valid while cmd_ready=0 is ignored. Command inputs are only sampled at accept.

Optional Feature:
LBUS_MASTER_AUTOINC_EN
- Defined:
  - Adds input cmd_len [7:0] (word count minus 1), sampled at accept.
  - After each word's GAP, go to ADDR with addr+2 (16-bit wrap 0xFFFE→0x0000) until cmd_len+1 words are done.
  - Writes take successive data from cmd_wdata: add output wdata_req. It is a one-cycle pulse in the last WRITE cycle of words 0..len-1, and the next cmd_wdata is sampled on the cycle after it.
  - Reads pulse rsp_valid once per word.
  - busy stays high across the whole burst.
- Undefined: single-word behaviour only; no cmd_len or wdata_req ports.

Test Plan:
- Reset: hold rst 3 cycles mid-sequence → wrn=rdn=1, lbus_di_a=0, cmd_ready=0 during rst, cmd_ready=1 one cycle after release.
- Write 0x0100←0xA5A5 (defaults) → 1 cycle lbus_di_a=0x0100 wrn=1; 2 cycles 0xA5A5 wrn=0; 1 gap cycle 0x0100; busy high 4 cycles, no rsp_valid.
- Read 0x0002 with target model driving 0x1234 when rdn=0 → rdn low 3 cycles, rsp_valid single pulse, rsp_rdata=0x1234 held after.
- Back-to-back write then read with cmd_valid held high → second accept exactly 5 cycles after the first; strobes never overlap.
- Assert rst on 2nd READ cycle → no rsp_valid, rsp_rdata=0, rdn=1 next cycle.
- AUTOINC_EN, write burst cmd_len=3 at 0xFFFC → addresses 0xFFFC, 0xFFFE, 0x0000, 0x0002; 3 wdata_req pulses; busy continuous.

Source files
------------

// File: rtl/lbus_master.sv
// ---------------------------------------------------------------------------
// lbus_master
// Local-bus initiator for the SASEBO-GIII 16-bit multiplexed local bus. It
// accepts one command at a time on a valid/ready handshake and runs one bus
// access per command: an address phase, then a write or read strobe phase,
// then an optional idle gap. Read data comes back on a one-cycle strobe.
//
// Optional feature (macro LBUS_MASTER_AUTOINC_EN):
//   Adds burst transfers. cmd_len (word count minus 1) is sampled at accept.
//   The address advances by 2 for each word. For write bursts, wdata_req asks
//   for the next write word.
//
// Parameters:
//   WR_CYC   cycles lbus_wrn is held low per write data phase (>= 1)
//   RD_CYC   cycles lbus_rdn is held low per read (>= 1)
//   GAP_CYC  idle cycles after each access with both strobes high (>= 0)
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_wr, cmd_addr,        command contents: 1 = write; bus address;
//   cmd_wdata                write data
//   cmd_len, wdata_req       (burst build only) burst length and write-data request
//   rsp_valid, rsp_rdata     one-cycle read-response strobe and held read data
//   busy                     high from accept until the bus returns to IDLE
//   lbus_di_a                multiplexed address/data to the target
//   lbus_wrn, lbus_rdn       active-low write and read strobes
//   lbus_do                  read data from the target
// ---------------------------------------------------------------------------
module lbus_master #(
   parameter int WR_CYC  = 2,
   parameter int RD_CYC  = 3,
   parameter int GAP_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
`ifdef LBUS_MASTER_AUTOINC_EN
   input  logic [7:0]  cmd_len,
   output logic        wdata_req,
`endif
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic [15:0] lbus_di_a,
   output logic        lbus_wrn,
   output logic        lbus_rdn,
   input  logic [15:0] lbus_do
);

   localparam int MAX_AB  = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
   localparam int MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WRITE,
      READ,
      GAP
   } stateT;

   stateT             state;
   stateT             nextState;
   logic [CNT_W-1:0]  phaseCnt;
   logic [CNT_W-1:0]  nextCnt;
   logic              wrQ;
   logic [15:0]       addrQ;
   logic [15:0]       wdataQ;
   logic [15:0]       nextAddr;
   logic [15:0]       nextWdata;
   logic [15:0]       diNext;
   logic              accept;
   logic              lastWrite;
   logic              lastRead;
   logic              lastGap;
   logic              moreWords;

   assign accept    = cmd_valid & cmd_ready;
   assign lastWrite = (state == WRITE) && (int'(phaseCnt) == WR_CYC - 1);
   assign lastRead  = (state == READ)  && (int'(phaseCnt) == RD_CYC - 1);
   assign lastGap   = (state == GAP)   && (int'(phaseCnt) == GAP_CYC - 1);

`ifdef LBUS_MASTER_AUTOINC_EN
   logic [7:0] wordsLeft;
   logic       wdataPend;
   logic       wordReentry;

   assign moreWords   = (wordsLeft != 8'd0);
   assign wordReentry = (state != IDLE) && (nextState == ADDR);
`else
   assign moreWords = 1'b0;
`endif

   // State register. Reset always returns the bus to IDLE, even in the
   // middle of an access. A partial command is simply abandoned.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. ADDR always lasts exactly one cycle. The strobe
   // phases and the gap are timed by the shared phase counter. When an
   // access or gap ends, the FSM either starts the next burst word at ADDR
   // or returns to IDLE. With GAP_CYC = 0 it skips GAP completely.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               nextState = ADDR;
            end
         end
         ADDR: begin
            nextState = wrQ ? WRITE : READ;
         end
         WRITE: begin
            if (lastWrite) begin
               nextState = (GAP_CYC > 0) ? GAP : (moreWords ? ADDR : IDLE);
            end
         end
         READ: begin
            if (lastRead) begin
               nextState = (GAP_CYC > 0) ? GAP : (moreWords ? ADDR : IDLE);
            end
         end
         GAP: begin
            if (lastGap) begin
               nextState = moreWords ? ADDR : IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // The phase counter restarts at zero on every state entry. It only counts
   // in the timed states, so it never runs past MAX_CYC-1 and cannot wrap.
   always_comb begin
      nextCnt = '0;
      if ((nextState == state) && (state != IDLE) && (state != ADDR)) begin
         nextCnt = phaseCnt + CNT_W'(1);
      end
   end

   // Address and write-data sources. The command is latched at accept.
   // Later inputs are ignored, except in burst mode, where each new burst
   // word steps the address and write data is reloaded one cycle after
   // wdata_req.
   always_comb begin
      nextAddr  = addrQ;
      nextWdata = wdataQ;
      if (accept) begin
         nextAddr  = cmd_addr;
         nextWdata = cmd_wdata;
      end
`ifdef LBUS_MASTER_AUTOINC_EN
      else begin
         if (wordReentry) begin
            nextAddr = addrQ + 16'd2;
         end
         if (wdataPend) begin
            nextWdata = cmd_wdata;
         end
      end
`endif
   end

   // The bus carries write data only while wrn is low. In every other state,
   // including IDLE, it carries the address. This way the target never sees
   // data while wrn is high and cannot latch data as an address.
   always_comb begin
      diNext = nextAddr;
      if (nextState == WRITE) begin
         diNext = nextWdata;
      end
   end

   // Registered datapath and outputs. Each output is computed from the state
   // the FSM enters next. So all outputs change on the same edge as the
   // state, and no output has a combinational path from an input.
   always_ff @(posedge clk) begin
      if (rst) begin
         phaseCnt  <= '0;
         wrQ       <= 1'b0;
         addrQ     <= 16'h0000;
         wdataQ    <= 16'h0000;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 16'h0000;
         lbus_di_a <= 16'h0000;
         lbus_wrn  <= 1'b1;
         lbus_rdn  <= 1'b1;
      end else begin
         phaseCnt  <= nextCnt;
         addrQ     <= nextAddr;
         wdataQ    <= nextWdata;
         if (accept) begin
            wrQ <= cmd_wr;
         end
         cmd_ready <= (nextState == IDLE);
         busy      <= (nextState != IDLE);
         lbus_di_a <= diNext;
         lbus_wrn  <= (nextState != WRITE);
         lbus_rdn  <= (nextState != READ);
         rsp_valid <= lastRead;
         if (lastRead) begin
            rsp_rdata <= lbus_do;
         end
      end
   end

`ifdef LBUS_MASTER_AUTOINC_EN
   // Burst bookkeeping. wordsLeft counts down once per word that starts
   // after the first. wdata_req fires in the last WRITE cycle of every word
   // except the final word. wdataPend marks the following cycle, when the
   // next word is taken from cmd_wdata.
   always_ff @(posedge clk) begin
      if (rst) begin
         wordsLeft <= 8'd0;
         wdataPend <= 1'b0;
         wdata_req <= 1'b0;
      end else begin
         if (accept) begin
            wordsLeft <= cmd_len;
         end else if (wordReentry) begin
            wordsLeft <= wordsLeft - 8'd1;
         end
         wdataPend <= wdata_req;
         wdata_req <= (nextState == WRITE) && (int'(nextCnt) == WR_CYC - 1) && moreWords;
      end
   end
`endif

endmodule

// File: tb/tb_lbus_master.sv
// ---------------------------------------------------------------------------
// tb_lbus_master
// Directed bench for lbus_master with its default parameters. A small target
// model latches the address while both strobes are high, stores write data,
// and returns stored data while rdn is low. Each read's expected data is
// queued when the command is issued. The queue is drained whenever
// rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_lbus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;
   logic [15:0] lbus_di_a;
   logic        lbus_wrn;
   logic        lbus_rdn;
   logic [15:0] lbus_do = 16'hDEAD;
`ifdef LBUS_MASTER_AUTOINC_EN
   logic [7:0]  cmd_len;
   logic        wdata_req;
   logic [15:0] burstData [4];
   logic [15:0] seenAddr [4];
   logic [15:0] expAddr [4];
   logic        prevWrn;
   logic [15:0] prevDi;
   int          nAddr;
   int          nReq;
   int          busyCycles;
`endif

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          t1;
   int          t2;
   logic [15:0] expQ [$];
   logic [15:0] monExp;
   logic [15:0] mem [logic [15:0]];
   logic [15:0] addrLatch = 16'h0000;
   logic [15:0] rndAddr;
   logic [15:0] rndData;

   always #5 clk = ~clk;

   lbus_master dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
`ifdef LBUS_MASTER_AUTOINC_EN
      .cmd_len   (cmd_len),
      .wdata_req (wdata_req),
`endif
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .lbus_di_a (lbus_di_a),
      .lbus_wrn  (lbus_wrn),
      .lbus_rdn  (lbus_rdn),
      .lbus_do   (lbus_do)
   );

   // Free-running cycle counter used to measure accept-to-accept spacing.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] memRead(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   // Target model: the address is latched while both strobes are high, and
   // data is stored while wrn is low.
   always @(posedge clk) begin
      if (lbus_wrn && lbus_rdn) addrLatch <= lbus_di_a;
      else if (!lbus_wrn) mem[addrLatch] = lbus_di_a;
   end

   // Read data is driven mid-cycle, so it is stable at the edge where the
   // master samples it.
   always @(negedge clk) begin
      lbus_do = !lbus_rdn ? memRead(addrLatch) : 16'hDEAD;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: the strobes must never both be low, and every rsp_valid must
   // match the oldest queued expectation.
   always @(negedge clk) begin
      checkOutput("strobeOverlap", 32'(!lbus_wrn && !lbus_rdn), 0);
      if (rsp_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedRsp", 32'(rsp_valid), 0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rspData", 32'(rsp_rdata), 32'(monExp));
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 100) begin
         stepCycle();
         n++;
      end
      checkOutput("idleWait", 32'(n < 100), 1);
   endtask

   // Presents one command and returns at #1 after the accepting edge, which
   // is the first ADDR cycle. The command inputs are then scrambled, so the
   // master's latching is what gets observed.
   task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic expectRsp, input logic [15:0] expData);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("readyWait", 32'(n < 50), 1);
      @(posedge clk);
      #1;
      if (expectRsp) expQ.push_back(expData);
      cmd_valid = 1'b0;
      cmd_wr    = ~wr;
      cmd_addr  = 16'($urandom);
      cmd_wdata = 16'($urandom);
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = 16'h0000;
      cmd_wdata = 16'h0000;
`ifdef LBUS_MASTER_AUTOINC_EN
      cmd_len   = 8'd0;
`endif
      mem[16'h0002] = 16'h1234;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstReady", 32'(cmd_ready), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstRspValid", 32'(rsp_valid), 0);
      checkOutput("rstRdata", 32'(rsp_rdata), 0);
      checkOutput("rstDi", 32'(lbus_di_a), 0);
      checkOutput("rstWrn", 32'(lbus_wrn), 1);
      checkOutput("rstRdn", 32'(lbus_rdn), 1);
      @(negedge clk);
      rst = 1'b0;
      stepCycle();
      checkOutput("readyAfterRst", 32'(cmd_ready), 1);

      // Single write 0x0100 <- 0xA5A5
      $display("[TB] single write");
      applyStimulus(1'b1, 16'h0100, 16'hA5A5, 1'b0, 16'h0000);
      checkOutput("wrAddrDi", 32'(lbus_di_a), 32'h0100);
      checkOutput("wrAddrWrn", 32'(lbus_wrn), 1);
      checkOutput("wrAddrBusy", 32'(busy), 1);
      checkOutput("wrAddrReady", 32'(cmd_ready), 0);
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         checkOutput("wrDataDi", 32'(lbus_di_a), 32'hA5A5);
         checkOutput("wrDataWrn", 32'(lbus_wrn), 0);
         checkOutput("wrDataRdn", 32'(lbus_rdn), 1);
         checkOutput("wrDataBusy", 32'(busy), 1);
      end
      stepCycle();
      checkOutput("wrGapDi", 32'(lbus_di_a), 32'h0100);
      checkOutput("wrGapWrn", 32'(lbus_wrn), 1);
      checkOutput("wrGapBusy", 32'(busy), 1);
      checkOutput("wrGapRsp", 32'(rsp_valid), 0);
      stepCycle();
      checkOutput("wrIdleBusy", 32'(busy), 0);
      checkOutput("wrIdleReady", 32'(cmd_ready), 1);

      // Single read 0x0002 with target returning 0x1234
      $display("[TB] single read");
      applyStimulus(1'b0, 16'h0002, 16'h0000, 1'b1, 16'h1234);
      checkOutput("rdAddrRdn", 32'(lbus_rdn), 1);
      checkOutput("rdAddrDi", 32'(lbus_di_a), 32'h0002);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("rdStrobeRdn", 32'(lbus_rdn), 0);
         checkOutput("rdStrobeDi", 32'(lbus_di_a), 32'h0002);
         checkOutput("rdStrobeRsp", 32'(rsp_valid), 0);
      end
      stepCycle();
      checkOutput("rdGapRdn", 32'(lbus_rdn), 1);
      checkOutput("rdGapRsp", 32'(rsp_valid), 1);
      checkOutput("rdGapData", 32'(rsp_rdata), 32'h1234);
      stepCycle();
      checkOutput("rdIdleRsp", 32'(rsp_valid), 0);
      checkOutput("rdIdleHold", 32'(rsp_rdata), 32'h1234);
      checkOutput("rdIdleBusy", 32'(busy), 0);

      // Back-to-back write then read with cmd_valid held
      $display("[TB] back-to-back");
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_wr    = 1'b1;
      cmd_addr  = 16'h0010;
      cmd_wdata = 16'hBEEF;
      @(posedge clk);
      #1;
      t1 = cyc;
      cmd_wr = 1'b0;
      begin
         int n = 0;
         @(negedge clk);
         while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         checkOutput("b2bReadyWait", 32'(n < 20), 1);
      end
      @(posedge clk);
      #1;
      t2 = cyc;
      expQ.push_back(16'hBEEF);
      cmd_valid = 1'b0;
      checkOutput("b2bSpacing", 32'(t2 - t1), 5);
      waitIdle();
      stepCycle();

      // Reset in the second READ cycle
      $display("[TB] reset mid-read");
      applyStimulus(1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000);
      stepCycle();
      stepCycle();
      checkOutput("midRdR2Rdn", 32'(lbus_rdn), 0);
      @(negedge clk);
      rst = 1'b1;
      stepCycle();
      checkOutput("midRdRdn", 32'(lbus_rdn), 1);
      checkOutput("midRdRsp", 32'(rsp_valid), 0);
      checkOutput("midRdData", 32'(rsp_rdata), 0);
      checkOutput("midRdBusy", 32'(busy), 0);
      checkOutput("midRdDi", 32'(lbus_di_a), 0);
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         checkOutput("midRdReadyInRst", 32'(cmd_ready), 0);
         checkOutput("midRdWrnInRst", 32'(lbus_wrn), 1);
      end
      @(negedge clk);
      rst = 1'b0;
      stepCycle();
      checkOutput("midRdReadyAfter", 32'(cmd_ready), 1);
      stepCycle();
      checkOutput("midRdNoRsp", 32'(rsp_valid), 0);

      // Write/read-back pairs at varied addresses
      $display("[TB] write/read pairs");
      for (int k = 0; k < 3; k++) begin
         rndAddr = 16'($urandom) & 16'hFFFE;
         rndData = 16'($urandom);
         applyStimulus(1'b1, rndAddr, rndData, 1'b0, 16'h0000);
         waitIdle();
         applyStimulus(1'b0, rndAddr, 16'h0000, 1'b1, rndData);
         waitIdle();
         stepCycle();
         checkOutput("pairRdata", 32'(rsp_rdata), 32'(rndData));
      end

`ifdef LBUS_MASTER_AUTOINC_EN
      // Burst write of 4 words starting at 0xFFFC
      $display("[TB] autoinc burst");
      burstData = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      expAddr   = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
      seenAddr  = '{16'h0, 16'h0, 16'h0, 16'h0};
      cmd_len = 8'd3;
      applyStimulus(1'b1, 16'hFFFC, burstData[0], 1'b0, 16'h0000);
      cmd_len    = 8'd0;
      prevWrn    = lbus_wrn;
      prevDi     = lbus_di_a;
      nAddr      = 0;
      nReq       = 0;
      busyCycles = 1;
      for (int i = 0; i < 40; i++) begin
         stepCycle();
         if (!lbus_wrn && prevWrn) begin
            if (nAddr < 4) seenAddr[nAddr] = prevDi;
            nAddr++;
         end
         if (wdata_req) begin
            nReq++;
            if (nReq < 4) cmd_wdata = burstData[nReq];
         end
         if (!busy) break;
         busyCycles++;
         prevWrn = lbus_wrn;
         prevDi  = lbus_di_a;
      end
      checkOutput("burstWords", 32'(nAddr), 4);
      checkOutput("burstReqs", 32'(nReq), 3);
      checkOutput("burstBusy", 32'(busyCycles), 16);
      for (int i = 0; i < 4; i++) begin
         checkOutput("burstAddr", 32'(seenAddr[i]), 32'(expAddr[i]));
         checkOutput("burstMem", 32'(memRead(expAddr[i])), 32'(burstData[i]));
      end
      stepCycle();
`endif

      repeat (3) stepCycle();
      checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the bench cannot hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
